// File: rtl/risc16_ctrl_fsm_pkg.sv
// Shared constants for the RiSC16 control sequencer: word width, PC-select
// codes, opcodes, ALU operation codes and write-back source codes.
package risc16_ctrl_fsm_pkg;

   localparam int RISC16_WORD_LEN = 16;

   localparam logic [1:0] SEL_PC_NPC    = 2'b00;
   localparam logic [1:0] SEL_PC_BRANCH = 2'b01;
   localparam logic [1:0] SEL_PC_ALU    = 2'b10;
   localparam logic [1:0] SEL_PC_HOLD   = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_NAND  = 2'b01;
   localparam logic [1:0] ALU_PASSB = 2'b10;
   localparam logic [1:0] ALU_CMP   = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_NPC = 2'b10;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_ADDI = 3'b001,
      OP_NAND = 3'b010,
      OP_LUI  = 3'b011,
      OP_SW   = 3'b100,
      OP_LW   = 3'b101,
      OP_BEQ  = 3'b110,
      OP_JALR = 3'b111
   } opcode_e;

endpackage

// File: rtl/risc16_decode.sv
// Combinational opcode -> control-class decode used by the sequencer.
module risc16_decode
   import risc16_ctrl_fsm_pkg::*;
(
   input  opcode_e    op_i,
   output logic       is_mem_o,
   output logic       is_lw_o,
   output logic       is_sw_o,
   output logic       is_beq_o,
   output logic       is_jalr_o,
   output logic       reg_wr_o,
   output logic [1:0] alu_op_o,
   output logic       imm_b_o
);

   // Per-opcode control flags; every opcode value is decoded.
   always_comb begin
      is_mem_o  = 1'b0;
      is_lw_o   = 1'b0;
      is_sw_o   = 1'b0;
      is_beq_o  = 1'b0;
      is_jalr_o = 1'b0;
      reg_wr_o  = 1'b0;
      alu_op_o  = ALU_ADD;
      imm_b_o   = 1'b0;
      case (op_i)
         OP_ADD:  begin reg_wr_o = 1'b1; end
         OP_ADDI: begin reg_wr_o = 1'b1; imm_b_o = 1'b1; end
         OP_NAND: begin reg_wr_o = 1'b1; alu_op_o = ALU_NAND; end
         OP_LUI:  begin reg_wr_o = 1'b1; alu_op_o = ALU_PASSB; imm_b_o = 1'b1; end
         OP_SW:   begin is_mem_o = 1'b1; is_sw_o = 1'b1; imm_b_o = 1'b1; end
         OP_LW:   begin is_mem_o = 1'b1; is_lw_o = 1'b1; reg_wr_o = 1'b1; imm_b_o = 1'b1; end
         OP_BEQ:  begin is_beq_o = 1'b1; alu_op_o = ALU_CMP; end
         OP_JALR: begin is_jalr_o = 1'b1; reg_wr_o = 1'b1; alu_op_o = ALU_PASSB; end
         default: ;
      endcase
   end

endmodule

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle control sequencer for the non-pipelined RiSC16 core.
// Optional feature macro: RISC16_HALT_EN (JALR with nonzero imm field halts).
//
// state  | meaning
// FETCH  | instruction being fetched, no strobes
// DECODE | instr stable, opcode captured on exit
// EXEC   | ALU controls driven
// MEM    | LW/SW strobe held until mem_ready or timeout
// WB     | register write and the single PC update
// HALT   | terminal until reset
module risc16_ctrl_fsm
   import risc16_ctrl_fsm_pkg::*;
#(
   parameter int WORD_LEN     = RISC16_WORD_LEN,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic [WORD_LEN-1:0] instr_i,
   input  logic                alu_eq_i,
   input  logic                mem_ready_i,
   output logic [1:0]          mux_pc_o,
   output logic [1:0]          alu_op_o,
   output logic                mux_alu_b_o,
   output logic                mem_re_o,
   output logic                mem_we_o,
   output logic                reg_we_o,
   output logic [1:0]          mux_wb_o,
   output logic                halted_o,
   output logic                bus_err_o
);

   localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   state_e         state_q, state_d;
   opcode_e        op_q, op_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           bus_err_q, bus_err_d;

   logic       dec_is_mem, dec_is_lw, dec_is_sw, dec_is_beq, dec_is_jalr, dec_reg_wr, dec_imm_b;
   logic [1:0] dec_alu_op;

`ifdef RISC16_HALT_EN
   logic halt_req_q, halt_req_d;
   logic halted_q, halted_d;
   logic unused_instr;
   assign unused_instr = ^instr_i[WORD_LEN-4:7];
`else
   logic unused_instr;
   assign unused_instr = ^instr_i[WORD_LEN-4:0];
`endif

   risc16_decode u_decode (
      .op_i      (op_q),
      .is_mem_o  (dec_is_mem),
      .is_lw_o   (dec_is_lw),
      .is_sw_o   (dec_is_sw),
      .is_beq_o  (dec_is_beq),
      .is_jalr_o (dec_is_jalr),
      .reg_wr_o  (dec_reg_wr),
      .alu_op_o  (dec_alu_op),
      .imm_b_o   (dec_imm_b)
   );

   // Next-state, opcode capture, wait-state counting and sticky flags.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wait_cnt_d = wait_cnt_q;
      bus_err_d  = bus_err_q;
`ifdef RISC16_HALT_EN
      halt_req_d = halt_req_q;
      halted_d   = halted_q;
`endif
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            state_d = ST_EXEC;
            op_d    = opcode_e'(instr_i[WORD_LEN-1 -: 3]);
`ifdef RISC16_HALT_EN
            halt_req_d = (opcode_e'(instr_i[WORD_LEN-1 -: 3]) == OP_JALR) && (instr_i[6:0] != 7'd0);
`endif
         end
         ST_EXEC: begin
            if (dec_is_mem) begin
               state_d    = ST_MEM;
               wait_cnt_d = '0;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            // ready has priority over a timeout in the same cycle
            if (mem_ready_i) begin
               state_d = ST_WB;
            end else if (wait_cnt_q == WCW'(MEM_WAIT_MAX - 1)) begin
               state_d   = ST_HALT;
               bus_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
`ifdef RISC16_HALT_EN
            if (halt_req_q) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end
`endif
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= ST_FETCH;
         op_q       <= OP_ADD;
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
`ifdef RISC16_HALT_EN
         halt_req_q <= 1'b0;
         halted_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
`ifdef RISC16_HALT_EN
         halt_req_q <= halt_req_d;
         halted_q   <= halted_d;
`endif
      end
   end

   // Moore output decode; forced to idle while reset is low so an aborted
   // instruction cannot write or move the PC on the reset edge.
   always_comb begin
      mux_pc_o    = SEL_PC_HOLD;
      alu_op_o    = ALU_ADD;
      mux_alu_b_o = 1'b0;
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      reg_we_o    = 1'b0;
      mux_wb_o    = WB_ALU;
      halted_o    = 1'b0;
      bus_err_o   = 1'b0;
      if (reset_ni) begin
         bus_err_o = bus_err_q;
`ifdef RISC16_HALT_EN
         halted_o = halted_q;
`endif
         case (state_q)
            ST_EXEC: begin
               alu_op_o    = dec_alu_op;
               mux_alu_b_o = dec_imm_b;
            end
            ST_MEM: begin
               alu_op_o    = dec_alu_op;
               mux_alu_b_o = dec_imm_b;
               mem_re_o    = dec_is_lw;
               mem_we_o    = dec_is_sw;
            end
            ST_WB: begin
               alu_op_o    = dec_alu_op;
               mux_alu_b_o = dec_imm_b;
`ifdef RISC16_HALT_EN
               if (!halt_req_q) begin
`else
               begin
`endif
                  reg_we_o = dec_reg_wr;
                  if (dec_is_beq && alu_eq_i) mux_pc_o = SEL_PC_BRANCH;
                  else if (dec_is_jalr)       mux_pc_o = SEL_PC_ALU;
                  else                        mux_pc_o = SEL_PC_NPC;
                  if (dec_is_lw)        mux_wb_o = WB_MEM;
                  else if (dec_is_jalr) mux_wb_o = WB_NPC;
                  else                  mux_wb_o = WB_ALU;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Self-checking bench for risc16_ctrl_fsm (build with or without RISC16_HALT_EN).
module tb_risc16_ctrl_fsm;

   localparam int MAXW = 4;
`ifdef RISC16_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [15:0] instr_i;
   logic        alu_eq_i;
   logic        mem_ready_i;
   logic [1:0]  mux_pc_o, alu_op_o, mux_wb_o;
   logic        mux_alu_b_o, mem_re_o, mem_we_o, reg_we_o, halted_o, bus_err_o;

   always #5 clk_i = ~clk_i;

   risc16_ctrl_fsm #(.WORD_LEN(16), .MEM_WAIT_MAX(MAXW)) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .instr_i     (instr_i),
      .alu_eq_i    (alu_eq_i),
      .mem_ready_i (mem_ready_i),
      .mux_pc_o    (mux_pc_o),
      .alu_op_o    (alu_op_o),
      .mux_alu_b_o (mux_alu_b_o),
      .mem_re_o    (mem_re_o),
      .mem_we_o    (mem_we_o),
      .reg_we_o    (reg_we_o),
      .mux_wb_o    (mux_wb_o),
      .halted_o    (halted_o),
      .bus_err_o   (bus_err_o)
   );

   typedef struct packed {
      logic [1:0] mux_pc;
      logic [1:0] alu_op;
      logic       alu_b;
      logic       re;
      logic       we;
      logic       reg_we;
      logic [1:0] mux_wb;
      logic       halted;
      logic       bus_err;
   } outs_t;

   typedef struct {
      logic [15:0] instr;
      logic        eq;
      int          waits;
      int          exp_len;
      logic [1:0]  exp_pc;
      logic        exp_reg_we;
      logic [1:0]  exp_wb;
      int          exp_re;
      int          exp_we;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   bit    m_bus_err, m_halted;
   outs_t exp_q[$];

   function automatic outs_t actual();
      outs_t o;
      o.mux_pc = mux_pc_o;  o.alu_op = alu_op_o; o.alu_b = mux_alu_b_o;
      o.re = mem_re_o;      o.we = mem_we_o;     o.reg_we = reg_we_o;
      o.mux_wb = mux_wb_o;  o.halted = halted_o; o.bus_err = bus_err_o;
      return o;
   endfunction

   task automatic check_outs(input string name, input outs_t a, input outs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h (pc,alu,b,re,we,rwe,wb,halt,berr)", name, a, e);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, a, e);
      end
   endtask

   // ALU controls by opcode, straight from the instruction set table.
   function automatic logic [1:0] alu_of(input int op);
      case (op)
         2: return 2'b01;
         3: return 2'b10;
         6: return 2'b11;
         7: return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic imm_of(input int op);
      return (op == 1 || op == 3 || op == 4 || op == 5);
   endfunction

   function automatic outs_t idle_rec();
      outs_t r;
      r = '0;
      r.mux_pc  = 2'b11;
      r.halted  = m_halted;
      r.bus_err = m_bus_err;
      return r;
   endfunction

   // Reference: list of expected per-cycle outputs for one instruction.
   task automatic build_trace(input logic [15:0] instr, input logic eq, input int waits);
      int    op, n;
      bit    is_mem, hlt;
      outs_t ex, r;
      op     = int'(instr[15:13]);
      is_mem = (op == 4 || op == 5);
      hlt    = HALT_EN && op == 7 && instr[6:0] != 7'd0;
      exp_q.delete();
      exp_q.push_back(idle_rec());
      exp_q.push_back(idle_rec());
      ex = idle_rec();
      ex.alu_op = alu_of(op);
      ex.alu_b  = imm_of(op);
      exp_q.push_back(ex);
      if (is_mem) begin
         n = (waits < MAXW) ? waits + 1 : MAXW;
         for (int k = 0; k < n; k++) begin
            r = ex; r.re = (op == 5); r.we = (op == 4);
            exp_q.push_back(r);
         end
         if (waits >= MAXW) begin
            m_bus_err = 1'b1;
            for (int k = 0; k < 3; k++) exp_q.push_back(idle_rec());
            return;
         end
      end
      r = ex;
      if (!hlt) begin
         r.mux_pc = (op == 6 && eq) ? 2'b01 : (op == 7) ? 2'b10 : 2'b00;
         r.reg_we = !(op == 4 || op == 6);
         r.mux_wb = (op == 5) ? 2'b01 : (op == 7) ? 2'b10 : 2'b00;
      end
      exp_q.push_back(r);
      if (hlt) begin
         m_halted = 1'b1;
         for (int k = 0; k < 3; k++) exp_q.push_back(idle_rec());
      end
   endtask

   // Starts just after a posedge with the DUT in FETCH.
   task automatic run_trace(input string name, input logic [15:0] instr, input logic eq, input int waits);
      build_trace(instr, eq, waits);
      instr_i  = instr;
      alu_eq_i = eq;
      for (int i = 0; i < exp_q.size(); i++) begin
         mem_ready_i = (i >= 3 + waits);
         #1;
         check_outs($sformatf("%s instr=%h cyc%0d", name, instr, i), actual(), exp_q[i]);
         @(posedge clk_i); #1;
      end
   endtask

   task automatic observe(input logic [15:0] instr, input logic eq, input int waits,
                          output int len, output outs_t wb, output int re_n, output int we_n);
      outs_t o;
      bit    done;
      instr_i = instr; alu_eq_i = eq;
      len = 0; re_n = 0; we_n = 0; wb = '0; done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         mem_ready_i = (i >= 3 + waits);
         #1;
         o = actual();
         if (o.mux_pc != 2'b11) begin
            len = i + 1; wb = o; done = 1'b1;
         end else begin
            re_n += int'(o.re);
            we_n += int'(o.we);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic do_reset();
      outs_t rst_exp;
      rst_exp = '0;
      rst_exp.mux_pc = 2'b11;
      reset_ni = 1'b0; instr_i = 16'h0000; alu_eq_i = 1'b0; mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #2;
         check_outs($sformatf("reset cyc%0d", i), actual(), rst_exp);
      end
      reset_ni = 1'b1;
      m_bus_err = 1'b0; m_halted = 1'b0;
   endtask

   vec_t  vecs[$];
   vec_t  v;
   int    len, re_n, we_n;
   outs_t wb, o, rst_exp;
   logic [15:0] ri;

   initial begin
      vecs.push_back('{16'h2081, 1'b0, 0, 4, 2'b00, 1'b1, 2'b00, 0, 0});
      vecs.push_back('{16'h0000, 1'b0, 0, 4, 2'b00, 1'b1, 2'b00, 0, 0});
      vecs.push_back('{16'h4000, 1'b0, 0, 4, 2'b00, 1'b1, 2'b00, 0, 0});
      vecs.push_back('{16'h6000, 1'b0, 0, 4, 2'b00, 1'b1, 2'b00, 0, 0});
      vecs.push_back('{16'hC000, 1'b1, 0, 4, 2'b01, 1'b0, 2'b00, 0, 0});
      vecs.push_back('{16'hC000, 1'b0, 0, 4, 2'b00, 1'b0, 2'b00, 0, 0});
      vecs.push_back('{16'hA000, 1'b0, 3, 8, 2'b00, 1'b1, 2'b01, 4, 0});
      vecs.push_back('{16'hA000, 1'b0, 0, 5, 2'b00, 1'b1, 2'b01, 1, 0});
      vecs.push_back('{16'h8000, 1'b0, 2, 7, 2'b00, 1'b0, 2'b00, 0, 3});
      vecs.push_back('{16'h8000, 1'b0, 3, 8, 2'b00, 1'b0, 2'b00, 0, 4});
      vecs.push_back('{16'hE000, 1'b0, 0, 4, 2'b10, 1'b1, 2'b10, 0, 0});
      if (!HALT_EN) vecs.push_back('{16'hE001, 1'b0, 0, 4, 2'b10, 1'b1, 2'b10, 0, 0});

      do_reset();
      run_trace("after_reset", 16'h0000, 1'b0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         observe(v.instr, v.eq, v.waits, len, wb, re_n, we_n);
         check_int($sformatf("vec%0d len", i), len, v.exp_len);
         check_int($sformatf("vec%0d mux_pc", i), int'(wb.mux_pc), int'(v.exp_pc));
         check_int($sformatf("vec%0d reg_we", i), int'(wb.reg_we), int'(v.exp_reg_we));
         check_int($sformatf("vec%0d mux_wb", i), int'(wb.mux_wb), int'(v.exp_wb));
         check_int($sformatf("vec%0d re_cycles", i), re_n, v.exp_re);
         check_int($sformatf("vec%0d we_cycles", i), we_n, v.exp_we);
      end

      for (int i = 0; i < 40; i++) begin
         ri = 16'($urandom);
         if (HALT_EN && ri[15:13] == 3'b111) ri[6:0] = 7'd0;
         run_trace("rand", ri, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAXW - 1)));
      end

      // SW that never completes: timeout into HALT, stays there
      run_trace("timeout", 16'h8000, 1'b0, 99);
      mem_ready_i = 1'b1; instr_i = 16'h2081;
      repeat (3) @(posedge clk_i);
      #1;
      o = idle_rec();
      check_outs("timeout stuck", actual(), o);

      do_reset();
      run_trace("jalr_imm", 16'hE001, 1'b0, 0);

      // reset asserted while in MEM aborts the access
      do_reset();
      instr_i = 16'hA000; mem_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_int("rstmem re before", int'(mem_re_o), 1);
      reset_ni = 1'b0;
      #1;
      rst_exp = '0; rst_exp.mux_pc = 2'b11;
      check_outs("rstmem during", actual(), rst_exp);
      @(posedge clk_i); #1;
      reset_ni = 1'b1; m_bus_err = 1'b0; m_halted = 1'b0;
      run_trace("rstmem after", 16'h2081, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
